// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, BYPASS opcode helper and IR capture pattern.
package jtag_pkg;

  localparam int IR_MAX_WIDTH = 32;

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PA_DR  = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'ha,
    SH_IR  = 4'hb,
    EX1_IR = 4'hc,
    PA_IR  = 4'hd,
    EX2_IR = 4'he,
    UPD_IR = 4'hf
  } tap_state_t;

  // Loaded into the IR shift register in CAP_IR; callers truncate to their IR width.
  localparam logic [IR_MAX_WIDTH-1:0] IR_CAPTURE_PAT = 32'h0000_0001;

  // All-ones BYPASS opcode for an IR of the given width.
  function automatic logic [IR_MAX_WIDTH-1:0] bypass_code(input int width);
    logic [IR_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < IR_MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP controller state machine; TMS sampled on every rising tck.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_next;

  always_ff @(posedge tck) begin
    if (!trst_n) state <= TLR;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:     state_next = tms ? TLR    : RTI;
      RTI:     state_next = tms ? SEL_DR : RTI;
      SEL_DR:  state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = tms ? EX1_DR : SH_DR;
      SH_DR:   state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next = tms ? UPD_DR : PA_DR;
      PA_DR:   state_next = tms ? EX2_DR : PA_DR;
      EX2_DR:  state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next = tms ? SEL_DR : RTI;
      SEL_IR:  state_next = tms ? TLR    : CAP_IR;
      CAP_IR:  state_next = tms ? EX1_IR : SH_IR;
      SH_IR:   state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next = tms ? UPD_IR : PA_IR;
      PA_IR:   state_next = tms ? EX2_IR : PA_IR;
      EX2_IR:  state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP with instruction register, bypass register and registered TDO; drives
// chain select and DR controls for an external boundary-scan chain mux.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int CHAIN_NUM = 2,
  parameter int IR_WIDTH  = 4,
  parameter int SEL_WIDTH = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic                 tms,
  input  logic                 tdi,
  input  logic                 scan_reg_out,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 chain_capture,
  output logic                 chain_shift,
  output logic                 chain_update,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic [3:0]           state_dbg
);

  localparam logic [IR_WIDTH-1:0] BYPASS    = IR_WIDTH'(bypass_code(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE_PAT);
  localparam logic [IR_WIDTH-1:0] CHAIN_LIM = IR_WIDTH'(CHAIN_NUM);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic                scan_active;

  tap_fsm u_tap_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tms    (tms),
    .state  (state)
  );

  assign state_dbg = state;

  // Opcodes below CHAIN_NUM select a chain; every other opcode behaves as BYPASS.
  assign scan_active   = (ir < CHAIN_LIM);
  assign sel           = scan_active ? ir[SEL_WIDTH-1:0] : '0;
  assign chain_capture = scan_active && (state == CAP_DR);
  assign chain_shift   = scan_active && (state == SH_DR);
  assign chain_update  = scan_active && (state == UPD_DR);

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      ir       <= BYPASS;
      ir_shift <= BYPASS;
    end else begin
      case (state)
        TLR: begin
          ir       <= BYPASS;
          ir_shift <= BYPASS;
        end
        CAP_IR:  ir_shift <= IR_CAP;
        // Right shift: tdi enters at the MSB, LSB leaves towards tdo.
        SH_IR:   ir_shift <= IR_WIDTH'({tdi, ir_shift} >> 1);
        UPD_IR:  ir       <= ir_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      bypass_reg <= 1'b0;
      tdo        <= 1'b0;
      tdo_en     <= 1'b0;
    end else begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
      case (state)
        CAP_DR: begin
          if (!scan_active) bypass_reg <= 1'b0;
        end
        SH_DR: begin
          tdo_en <= 1'b1;
          if (scan_active) begin
            tdo <= scan_reg_out;
          end else begin
            tdo        <= bypass_reg;
            bypass_reg <= tdi;
          end
        end
        SH_IR: begin
          tdo_en <= 1'b1;
          tdo    <= ir_shift[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IR load, SCAN and BYPASS DR scans, reset mid-shift.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  logic       tck = 1'b0;
  logic       trst_n = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       scan_reg_out = 1'b0;
  logic [0:0] sel;
  logic       chain_capture;
  logic       chain_shift;
  logic       chain_update;
  logic       tdo;
  logic       tdo_en;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cap_cnt = 0;
  int shf_cnt = 0;
  int upd_cnt = 0;

  logic [7:0] pat;
  logic [3:0] tdi_vec;
  logic [3:0] tdo_vec;

  always #5 tck = ~tck;

  jtag_tap_ctrl dut (
    .tck           (tck),
    .trst_n        (trst_n),
    .tms           (tms),
    .tdi           (tdi),
    .scan_reg_out  (scan_reg_out),
    .sel           (sel),
    .chain_capture (chain_capture),
    .chain_shift   (chain_shift),
    .chain_update  (chain_update),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One tck: drive inputs, tally the chain controls of the current state, settle after the edge.
  task automatic step(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    #1;
    if (chain_capture) cap_cnt++;
    if (chain_shift)   shf_cnt++;
    if (chain_update)  upd_cnt++;
    @(posedge tck);
    #1;
  endtask

  // From RTI: load an IR value (LSB first) and return to RTI.
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    // Reset wins over tms=0
    trst_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("rst_state", 32'(state_dbg), 32'(TLR));
    check("rst_tdo", 32'(tdo), 32'h0);
    check("rst_tdo_en", 32'(tdo_en), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_ctrl", 32'({chain_capture, chain_shift, chain_update}), 32'h0);

    // Wander into SH_DR, then five tms=1 back to TLR
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("wander_state", 32'(state_dbg), 32'(SH_DR));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("tlr5_state", 32'(state_dbg), 32'(TLR));
    check("tlr5_sel", 32'(sel), 32'h0);
    check("tlr5_tdo_en", 32'(tdo_en), 32'h0);

    // Load IR=0001: captured 0001 shifts out as 1,0,0,0
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("ir_sh_state", 32'(state_dbg), 32'(SH_IR));
    tdi_vec = 4'b0001;
    tdo_vec = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, tdi_vec[i]);
      check("ir_tdo", 32'(tdo), 32'(tdo_vec[i]));
      check("ir_tdo_en", 32'(tdo_en), 32'h1);
    end
    step(1'b1, 1'b0);
    check("upd_ir_state", 32'(state_dbg), 32'(UPD_IR));
    check("upd_ir_sel_old", 32'(sel), 32'h0);
    check("upd_ir_tdo_en", 32'(tdo_en), 32'h0);
    step(1'b0, 1'b0);
    check("scan1_sel", 32'(sel), 32'h1);

    // SCAN_1: 8-bit DR scan
    cap_cnt = 0; shf_cnt = 0; upd_cnt = 0;
    pat = 8'b10110010;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("scan_cap", 32'(chain_capture), 32'h1);
    check("scan_cap_shift", 32'(chain_shift), 32'h0);
    step(1'b0, 1'b0);
    check("scan_shift", 32'(chain_shift), 32'h1);
    check("scan_shift_cap", 32'(chain_capture), 32'h0);
    for (int k = 0; k < 8; k++) begin
      scan_reg_out = pat[7-k];
      step(k == 7, 1'($urandom_range(0, 1)));
      check("scan_tdo", 32'(tdo), 32'(pat[7-k]));
      check("scan_tdo_en", 32'(tdo_en), 32'h1);
    end
    step(1'b1, 1'b0);
    check("scan_upd", 32'(chain_update), 32'h1);
    check("scan_upd_tdo_en", 32'(tdo_en), 32'h0);
    check("scan_upd_tdo", 32'(tdo), 32'h0);
    step(1'b0, 1'b0);
    check("scan_cap_cnt", 32'(cap_cnt), 32'd1);
    check("scan_shf_cnt", 32'(shf_cnt), 32'd8);
    check("scan_upd_cnt", 32'(upd_cnt), 32'd1);

    // BYPASS: tdi 1,1,0,1 -> tdo 0,1,1,0 (bypass bit was left at 1 earlier)
    load_ir(4'b1111);
    check("byp_sel", 32'(sel), 32'h0);
    scan_reg_out = 1'b1;
    cap_cnt = 0; shf_cnt = 0; upd_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tdi_vec = 4'b1011;
    tdo_vec = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, tdi_vec[i]);
      check("byp_tdo", 32'(tdo), 32'(tdo_vec[i]));
      check("byp_tdo_en", 32'(tdo_en), 32'h1);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("byp_ctrl_cnt", 32'(cap_cnt + shf_cnt + upd_cnt), 32'd0);

    // Unused opcode 0111 behaves as BYPASS
    load_ir(4'b0111);
    check("unused_sel", 32'(sel), 32'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("unused_shift", 32'(chain_shift), 32'h0);
    step(1'b0, 1'b1);
    check("unused_tdo0", 32'(tdo), 32'h0);
    step(1'b1, 1'b0);
    check("unused_tdo1", 32'(tdo), 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // SCAN_0: sel 0 but chain controls active
    load_ir(4'b0000);
    check("scan0_sel", 32'(sel), 32'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("scan0_cap", 32'(chain_capture), 32'h1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("scan0_upd", 32'(chain_update), 32'h1);
    step(1'b0, 1'b0);

    // Reset in the middle of a SCAN_1 DR shift
    load_ir(4'b0001);
    check("mid_sel", 32'(sel), 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    scan_reg_out = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    cap_cnt = 0; shf_cnt = 0; upd_cnt = 0;
    trst_n = 1'b0;
    step(1'b0, 1'b1);
    check("mid_rst_state", 32'(state_dbg), 32'(TLR));
    check("mid_rst_tdo", 32'(tdo), 32'h0);
    check("mid_rst_tdo_en", 32'(tdo_en), 32'h0);
    check("mid_rst_sel", 32'(sel), 32'h0);
    trst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("mid_rst_upd_cnt", 32'(upd_cnt), 32'd0);
    check("mid_rst_rti_sel", 32'(sel), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
